// File: rtl/atd_sampler.sv
// atd_sampler: ATD receive front end.
//   Synchronizes the asynchronous ATD_clk/ATD_data pair into the clk domain,
//   rejects ATD_clk glitches shorter than FILTER_LEN synced samples, takes one
//   bit per qualified rising edge and assembles WORD_W-bit words MSB-first.
// Ports:
//   clk, n_rst        system clock, asynchronous active-low reset
//   ATD_clk, ATD_data async serial bit clock and data (data valid at clk rise)
//   enable            1 = receive; 0 = idle, clears progress and overrun
//   data_taken        consumer has read hold_word (1-cycle pulse)
//   ATD_shift_enable  1-cycle pulse per accepted bit
//   shift_data        live shift register, MSB-first
//   bit_count         bits held in the current partial word
//   hold_word         last completed word
//   word_pending      hold_word valid and unread
//   overrun           sticky: a word completed while the previous one was unread
module atd_sampler #(
  parameter int unsigned FILTER_LEN = 2,
  parameter int unsigned WORD_W     = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              ATD_clk,
  input  logic              ATD_data,
  input  logic              enable,
  input  logic              data_taken,
  output logic              ATD_shift_enable,
  output logic [WORD_W-1:0] shift_data,
  output logic [4:0]        bit_count,
  output logic [WORD_W-1:0] hold_word,
  output logic              word_pending,
  output logic              overrun
);

  localparam logic [3:0] FLEN     = 4'(FILTER_LEN);
  localparam logic [4:0] LAST_BIT = 5'(WORD_W - 1);

  typedef enum logic [1:0] {
    LOW,
    RISE_QUAL,
    HIGH,
    FALL_QUAL
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        qcnt_q, qcnt_d;
  logic              cap_q, cap_d;
  logic              armed_q;
  logic [1:0]        clk_sync_q, data_sync_q;
  logic              clk_s, data_s;

  logic              pulse_q, pulse_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [4:0]        bcnt_q, bcnt_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              pend_q, pend_d;
  logic              ovr_q, ovr_d;

  logic              accept;
  logic              acc_bit;
  logic              complete;
  logic [WORD_W-1:0] shift_next;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // Identical chains keep clk_s and data_s mutually aligned.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ATD_clk};
      data_sync_q <= {data_sync_q[0], ATD_data};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= LOW;
      qcnt_q  <= '0;
      cap_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      cap_q   <= cap_d;
      armed_q <= enable;
    end
  end

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    cap_d   = cap_q;
    accept  = 1'b0;
    acc_bit = cap_q;
    unique case (state_q)
      LOW: begin
        if (clk_s) begin
          if (!armed_q) begin
            // First enabled cycle with the line already high: treat it as a
            // stale high so a qualified low is needed before any bit.
            state_d = HIGH;
          end else if (FLEN == 4'd1) begin
            accept  = 1'b1;
            acc_bit = data_s;
            state_d = HIGH;
          end else begin
            state_d = RISE_QUAL;
            qcnt_d  = 4'd1;
            cap_d   = data_s;
          end
        end
      end
      RISE_QUAL: begin
        if (!clk_s) begin
          state_d = LOW;
        end else begin
          qcnt_d = qcnt_q + 4'd1;
          if (qcnt_q + 4'd1 == FLEN) begin
            accept  = 1'b1;
            state_d = HIGH;
          end
        end
      end
      HIGH: begin
        if (!clk_s) begin
          if (FLEN == 4'd1) begin
            state_d = LOW;
          end else begin
            state_d = FALL_QUAL;
            qcnt_d  = 4'd1;
          end
        end
      end
      FALL_QUAL: begin
        if (clk_s) begin
          state_d = HIGH;
        end else begin
          qcnt_d = qcnt_q + 4'd1;
          if (qcnt_q + 4'd1 == FLEN) begin
            state_d = LOW;
          end
        end
      end
      default: state_d = LOW;
    endcase
    if (!enable) begin
      state_d = LOW;
      accept  = 1'b0;
    end
  end

  assign shift_next = {shift_q[WORD_W-2:0], acc_bit};
  assign complete   = accept && (bcnt_q == LAST_BIT);

  always_comb begin
    pulse_d = accept;
    shift_d = accept ? shift_next : shift_q;
    bcnt_d  = bcnt_q;
    if (accept) begin
      bcnt_d = complete ? 5'd0 : bcnt_q + 5'd1;
    end
    hold_d = complete ? shift_next : hold_q;
    // Completion beats a simultaneous data_taken: the new word stays pending.
    pend_d = complete ? 1'b1 : (data_taken ? 1'b0 : pend_q);
    ovr_d  = ovr_q | (complete & pend_q & ~data_taken);
    if (!enable) begin
      pulse_d = 1'b0;
      shift_d = '0;
      bcnt_d  = '0;
      pend_d  = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pulse_q <= 1'b0;
      shift_q <= '0;
      bcnt_q  <= '0;
      hold_q  <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ATD_shift_enable = pulse_q;
  assign shift_data       = shift_q;
  assign bit_count        = bcnt_q;
  assign hold_word        = hold_q;
  assign word_pending     = pend_q;
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_atd_sampler.sv
module tb_atd_sampler;

  logic        clk = 1'b0;
  logic        n_rst, enable, data_taken;
  logic        ATD_clk, ATD_data, ATD_clk1, ATD_data1;
  logic        pulse, pulse1;
  logic [15:0] shift_data, hold_word, shift_data1, hold_word1;
  logic [4:0]  bit_count, bit_count1;
  logic        word_pending, overrun, word_pending1, overrun1;

  always #5 clk = ~clk;

  atd_sampler #(.FILTER_LEN(2), .WORD_W(16)) dut (
    .clk(clk), .n_rst(n_rst), .ATD_clk(ATD_clk), .ATD_data(ATD_data),
    .enable(enable), .data_taken(data_taken), .ATD_shift_enable(pulse),
    .shift_data(shift_data), .bit_count(bit_count), .hold_word(hold_word),
    .word_pending(word_pending), .overrun(overrun)
  );

  atd_sampler #(.FILTER_LEN(1), .WORD_W(16)) dut1 (
    .clk(clk), .n_rst(n_rst), .ATD_clk(ATD_clk1), .ATD_data(ATD_data1),
    .enable(enable), .data_taken(data_taken), .ATD_shift_enable(pulse1),
    .shift_data(shift_data1), .bit_count(bit_count1), .hold_word(hold_word1),
    .word_pending(word_pending1), .overrun(overrun1)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int pulses1 = 0;

  // Reference model: word assembly from accepted bits, plain arithmetic.
  logic [15:0] m_shift, m_hold, m1_shift;
  int          m_cnt, m1_cnt;
  logic        m_pend, m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pulse === 1'b1) pulses++;
    if (pulse1 === 1'b1) pulses1++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_state(input string tag);
    check({tag, "_shift"}, 32'(shift_data), 32'(m_shift));
    check({tag, "_bcnt"},  32'(bit_count),  32'(m_cnt));
    check({tag, "_hold"},  32'(hold_word),  32'(m_hold));
    check({tag, "_pend"},  32'(word_pending), 32'(m_pend));
    check({tag, "_ovr"},   32'(overrun),    32'(m_ovr));
  endtask

  // One bit on the FILTER_LEN=2 instance; take_at_done raises data_taken for
  // the cycle in which this bit's accept edge occurs (4 edges after the rise).
  task automatic send_bit(input logic b, input int ph, input bit take_at_done);
    int p0, first;
    p0 = pulses;
    first = 0;
    ATD_data = b;
    ATD_clk  = 1'b1;
    for (int i = 1; i <= 2 * ph; i++) begin
      if (i == ph + 1) ATD_clk = 1'b0;
      if (take_at_done && i == 4) data_taken = 1'b1;
      tick();
      data_taken = 1'b0;
      if (first == 0 && pulses != p0) first = i;
    end
    check("pulse_cnt", 32'(pulses - p0), 32'd1);
    check("latency", 32'(first), 32'd4);
    m_shift = {m_shift[14:0], b};
    if (m_cnt == 15) begin
      m_cnt = 0;
      if (m_pend && !take_at_done) m_ovr = 1'b1;
      m_hold = m_shift;
      m_pend = 1'b1;
    end else begin
      m_cnt++;
    end
    check("bit_shift", 32'(shift_data), 32'(m_shift));
    check("bit_bcnt", 32'(bit_count), 32'(m_cnt));
  endtask

  task automatic send_word(input logic [15:0] w, input int ph, input bit take_last);
    for (int k = 15; k >= 0; k--) send_bit(w[k], ph, take_last && k == 0);
  endtask

  task automatic take();
    data_taken = 1'b1;
    tick();
    data_taken = 1'b0;
    m_pend = 1'b0;
    check("take_pend", 32'(word_pending), 32'(m_pend));
  endtask

  task automatic enable_pulse();
    enable = 1'b0;
    ticks(2);
    enable = 1'b1;
    ticks(2);
    m_shift = '0;
    m_cnt   = 0;
    m_pend  = 1'b0;
    m_ovr   = 1'b0;
    m1_shift = '0;
    m1_cnt   = 0;
  endtask

  task automatic send_bit1(input logic b);
    int p0, first;
    p0 = pulses1;
    first = 0;
    ATD_data1 = b;
    ATD_clk1  = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if (i == 4) ATD_clk1 = 1'b0;
      tick();
      if (first == 0 && pulses1 != p0) first = i;
    end
    check("f1_pulse_cnt", 32'(pulses1 - p0), 32'd1);
    check("f1_latency", 32'(first), 32'd3);
    m1_shift = {m1_shift[14:0], b};
    m1_cnt   = (m1_cnt + 1) % 16;
  endtask

  initial begin
    logic [15:0] w;
    int p0;
    n_rst = 1'b0; enable = 1'b1; data_taken = 1'b0;
    ATD_clk = 1'b0; ATD_data = 1'b0; ATD_clk1 = 1'b0; ATD_data1 = 1'b0;
    m_shift = '0; m_hold = '0; m_cnt = 0; m_pend = 1'b0; m_ovr = 1'b0;
    m1_shift = '0; m1_cnt = 0;
    ticks(3);
    check_state("reset");
    check("reset_pulse", 32'(pulse), 32'd0);
    check("reset_shift1", 32'(shift_data1), 32'd0);
    n_rst = 1'b1;
    ticks(3);

    // Basic word
    send_word(16'hA5C3, 12, 1'b0);
    check_state("word_a5c3");

    // Glitch mid-word
    take();
    for (int k = 0; k < 5; k++) send_bit(1'($urandom), 8, 1'b0);
    p0 = pulses;
    ATD_clk = 1'b1;
    tick();
    ATD_clk = 1'b0;
    ticks(8);
    check("glitch_pulses", 32'(pulses - p0), 32'd0);
    check_state("glitch");
    for (int k = 0; k < 11; k++) send_bit(1'($urandom), 8, 1'b0);
    check_state("after_glitch");

    // Overrun, then cleared by enable
    enable_pulse();
    check_state("en_clear0");
    send_word(16'h1234, 6, 1'b0);
    send_word(16'hBEEF, 6, 1'b0);
    check_state("overrun");
    enable_pulse();
    check_state("en_clear");

    // Line already high when enable rises: no bit taken from the stale high
    enable = 1'b0;
    ATD_clk = 1'b1;
    ATD_data = 1'b1;
    ticks(3);
    enable = 1'b1;
    p0 = pulses;
    ticks(10);
    ATD_clk = 1'b0;
    ticks(8);
    check("stale_high_pulses", 32'(pulses - p0), 32'd0);
    check_state("stale_high");

    // data_taken in the completion cycle of a second unread word
    send_word(16'h1357, 8, 1'b0);
    send_word(16'h00FF, 8, 1'b1);
    check_state("take_at_done");

    // Async reset mid-word
    for (int k = 0; k < 7; k++) send_bit(1'($urandom), 6, 1'b0);
    n_rst = 1'b0;
    #1;
    m_shift = '0; m_hold = '0; m_cnt = 0; m_pend = 1'b0; m_ovr = 1'b0;
    check_state("mid_reset");
    check("mid_reset_pulse", 32'(pulse), 32'd0);
    ticks(2);
    n_rst = 1'b1;
    ticks(3);
    w = 16'($urandom);
    send_word(w, 6, 1'b0);
    check_state("post_reset");

    // Randomized words, phases and reads
    for (int n = 0; n < 5; n++) begin
      w = 16'($urandom);
      send_word(w, int'($urandom_range(12, 4)), 1'b0);
      check_state("rand_word");
      if ($urandom_range(1, 0) == 1) take();
      ticks(int'($urandom_range(5, 0)));
    end
    enable_pulse();
    check_state("rand_clear");

    // FILTER_LEN=1 instance at 3 clk per phase
    w = 16'($urandom);
    for (int k = 15; k >= 0; k--) send_bit1(w[k]);
    check("f1_hold", 32'(hold_word1), 32'(w));
    check("f1_shift", 32'(shift_data1), 32'(m1_shift));
    check("f1_bcnt", 32'(bit_count1), 32'(m1_cnt));
    check("f1_pend", 32'(word_pending1), 32'd1);
    check("f1_ovr", 32'(overrun1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
